// File: rtl/smg_pkg.sv
// Shared constants, state encoding and small helpers for the six-digit
// segment-display scan controller.
package smg_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [5:0] COL_OFF    = 6'h3F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  // Active-low one-hot select of the addressed digit.
  function automatic logic [5:0] col_select(input digit_idx_t idx);
    return ~(6'b000001 << idx);
  endfunction

  function automatic digit_idx_t next_digit(input digit_idx_t idx);
    return (idx == LAST_DIGIT) ? digit_idx_t'(0) : idx + 3'd1;
  endfunction

endpackage

// File: rtl/smg_dwell_timer.sv
// Per-state cycle counter (BLANK / DWELL lengths) and the 4-bit PWM phase
// counter that runs during SHOW.
module smg_dwell_timer
  import smg_pkg::*;
#(
  parameter int DWELL = 20,
  parameter int BLANK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  scan_state_e state,
  output logic [3:0]  phase,
  output logic        first,
  output logic        done
);

  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  phase_q, phase_d;

  assign done  = (state == ST_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == DWELL_LAST);
  assign first = (cnt_q == 16'd0);
  assign phase = phase_q;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d   = cnt_q + 16'd1;
    phase_d = 4'd0;
    // Phase rests at zero in BLANK, so the first SHOW cycle sees phase 0.
    if (state == ST_SHOW) phase_d = phase_q + 4'd1;
    if (clear || done)    cnt_d   = 16'd0;
    if (clear)            phase_d = 4'd0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 16'd0;
      phase_q <= 4'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Six-digit multiplexed segment display scanner: BLANK/SHOW sequencing,
// PWM brightness, shadowed digit data with a frame-boundary update handshake.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int DWELL = 20,
  parameter int BLANK = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Enable,
  input  logic [3:0] Brightness,
  input  logic       Upd_Req,
  input  logic [7:0] Ten_SMG_Data0,
  input  logic [7:0] One_SMG_Data0,
  input  logic [7:0] Ten_SMG_Data1,
  input  logic [7:0] One_SMG_Data1,
  input  logic [7:0] Ten_SMG_Data2,
  input  logic [7:0] One_SMG_Data2,
  output logic       Upd_Ack,
  output logic [7:0] Row_Scan_Sig,
  output logic [5:0] Column_Scan_Sig,
  output logic [2:0] Digit_Idx,
  output logic       Frame_Start
);

  scan_state_e state_q, state_d;
  digit_idx_t  digit_q, digit_d;
  logic [7:0]  shadow_q [NUM_DIGITS];
  logic [7:0]  shadow_d [NUM_DIGITS];
  logic        req_seen_q, req_seen_d;
  logic        ack_q, ack_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  digit_idx_t  digit_out_q, digit_out_d;

  logic        capture;
  logic        timer_clear;
  logic        timer_first;
  logic        timer_done;
  logic [3:0]  phase;

  assign timer_clear = ~Enable;

  smg_dwell_timer #(
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) u_timer (
    .clk   (CLK),
    .rst   (RST),
    .clear (timer_clear),
    .state (state_q),
    .phase (phase),
    .first (timer_first),
    .done  (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    shadow_d   = shadow_q;
    req_seen_d = req_seen_q;
    capture    = 1'b0;

    if (!Enable) begin
      // Dark display: hold at digit 0 BLANK and serve requests at once.
      state_d = ST_BLANK;
      digit_d = '0;
      capture = Upd_Req && !req_seen_q;
    end else if (timer_done) begin
      if (state_q == ST_BLANK) begin
        state_d = ST_SHOW;
      end else begin
        state_d = ST_BLANK;
        digit_d = next_digit(digit_q);
        capture = (digit_q == LAST_DIGIT) && Upd_Req && !req_seen_q;
      end
    end

    // req_seen blocks a re-capture until the requester drops Upd_Req.
    if (capture) begin
      shadow_d[0] = Ten_SMG_Data0;
      shadow_d[1] = One_SMG_Data0;
      shadow_d[2] = Ten_SMG_Data1;
      shadow_d[3] = One_SMG_Data1;
      shadow_d[4] = Ten_SMG_Data2;
      shadow_d[5] = One_SMG_Data2;
      req_seen_d  = 1'b1;
    end else if (!Upd_Req) begin
      req_seen_d  = 1'b0;
    end

    ack_d         = capture;
    frame_start_d = Enable && (state_q == ST_BLANK) && (digit_q == '0) && timer_first;

    row_d = SEG_OFF;
    col_d = COL_OFF;
    if (Enable && (state_q == ST_SHOW) && (phase < Brightness)) begin
      row_d = shadow_q[digit_q];
      col_d = col_select(digit_q);
    end
    digit_out_d = Enable ? digit_q : digit_idx_t'(0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_BLANK;
      digit_q       <= '0;
      // NOTE: the shadow array is reset because its contents reach the pins
      // directly; an unreset memory would show garbage until the first update.
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= SEG_OFF;
      req_seen_q    <= 1'b0;
      ack_q         <= 1'b0;
      frame_start_q <= 1'b0;
      row_q         <= SEG_OFF;
      col_q         <= COL_OFF;
      digit_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= shadow_d[i];
      req_seen_q    <= req_seen_d;
      ack_q         <= ack_d;
      frame_start_q <= frame_start_d;
      row_q         <= row_d;
      col_q         <= col_d;
      digit_out_q   <= digit_out_d;
    end
  end

  assign Upd_Ack         = ack_q;
  assign Frame_Start     = frame_start_q;
  assign Row_Scan_Sig    = row_q;
  assign Column_Scan_Sig = col_q;
  assign Digit_Idx       = digit_out_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Directed bench for smg_scan_ctrl with DWELL=20, BLANK=4 (144-cycle frame);
// expected values come from frame position arithmetic and hand-set tables.
module tb_smg_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Enable;
  logic [3:0] Brightness;
  logic       Upd_Req;
  logic [7:0] din [6];
  logic       Upd_Ack;
  logic [7:0] Row_Scan_Sig;
  logic [5:0] Column_Scan_Sig;
  logic [2:0] Digit_Idx;
  logic       Frame_Start;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_seg [6];

  always #5 CLK = ~CLK;

  smg_scan_ctrl #(
    .DWELL (20),
    .BLANK (4)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .Enable          (Enable),
    .Brightness      (Brightness),
    .Upd_Req         (Upd_Req),
    .Ten_SMG_Data0   (din[0]),
    .One_SMG_Data0   (din[1]),
    .Ten_SMG_Data1   (din[2]),
    .One_SMG_Data1   (din[3]),
    .Ten_SMG_Data2   (din[4]),
    .One_SMG_Data2   (din[5]),
    .Upd_Ack         (Upd_Ack),
    .Row_Scan_Sig    (Row_Scan_Sig),
    .Column_Scan_Sig (Column_Scan_Sig),
    .Digit_Idx       (Digit_Idx),
    .Frame_Start     (Frame_Start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_dark(input string tag, input logic exp_ack);
    check({tag, "_row"},   32'(Row_Scan_Sig),    32'h0000_00FF);
    check({tag, "_col"},   32'(Column_Scan_Sig), 32'h0000_003F);
    check({tag, "_digit"}, 32'(Digit_Idx),       32'd0);
    check({tag, "_fs"},    32'(Frame_Start),     32'd0);
    check({tag, "_ack"},   32'(Upd_Ack),         32'(exp_ack));
  endtask

  // Entered on the sample showing Frame_Start; frame position k maps to
  // digit k/24, BLANK for k%24 < 4, then SHOW with phase (k%24-4)%16.
  task automatic run_frame(input logic [3:0] bright, input int req_k,
                           input int ack_k, input int nk);
    Brightness = bright;
    for (int k = 0; k < nk; k++) begin
      int         dig;
      int         j;
      logic       lit;
      logic [7:0] row_exp;
      logic [5:0] col_exp;
      dig     = k / 24;
      j       = k % 24;
      lit     = (j >= 4) && (((j - 4) % 16) < int'(bright));
      row_exp = lit ? exp_seg[dig] : 8'hFF;
      col_exp = lit ? ~(6'b000001 << dig) : 6'h3F;
      check("frame_start", 32'(Frame_Start),     32'(k == 0));
      check("digit_idx",   32'(Digit_Idx),       32'(dig));
      check("row",         32'(Row_Scan_Sig),    32'(row_exp));
      check("col",         32'(Column_Scan_Sig), 32'(col_exp));
      check("upd_ack",     32'(Upd_Ack),         32'(k == ack_k));
      if (Upd_Ack) Upd_Req = 1'b0;
      if (k == req_k) Upd_Req = 1'b1;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST        = 1'b1;
    Enable     = 1'b0;
    Upd_Req    = 1'b0;
    Brightness = 4'd15;
    din[0] = 8'hF9; din[1] = 8'hA4; din[2] = 8'hB0;
    din[3] = 8'h99; din[4] = 8'h92; din[5] = 8'h82;
    for (int i = 0; i < 6; i++) exp_seg[i] = 8'hFF;

    tick();
    tick();
    check_dark("reset", 1'b0);
    RST = 1'b0;
    tick();
    check_dark("idle_disabled", 1'b0);

    // Disabled: request served at once, one Ack only while Req stays high.
    Upd_Req = 1'b1;
    tick();
    check_dark("load_ack", 1'b1);
    tick();
    check("ack_no_repeat1", 32'(Upd_Ack), 32'd0);
    tick();
    check("ack_no_repeat2", 32'(Upd_Ack), 32'd0);
    Upd_Req = 1'b0;
    tick();
    check("ack_after_drop", 32'(Upd_Ack), 32'd0);
    for (int i = 0; i < 6; i++) exp_seg[i] = din[i];

    // Enable rising: Frame_Start and digit 0 BLANK; full frames at 15, 4, 0.
    Enable = 1'b1;
    tick();
    run_frame(4'd15, -1, -1, 144);
    run_frame(4'd4,  -1, -1, 144);
    run_frame(4'd0,  -1, -1, 144);

    // Mid-frame request waits for the digit 5 boundary.
    din[0] = 8'hC0;
    din[5] = 8'h90;
    run_frame(4'd15, 30, 143, 144);
    exp_seg[0] = 8'hC0;
    exp_seg[5] = 8'h90;
    run_frame(4'd15, -1, -1, 144);

    // Enable low during SHOW of digit 3.
    run_frame(4'd15, -1, -1, 81);
    Enable  = 1'b0;
    Upd_Req = 1'b1;
    din[0]  = 8'h99;
    tick();
    check_dark("enable_low", 1'b1);
    Upd_Req = 1'b0;
    tick();
    check_dark("enable_low_hold", 1'b0);
    tick();
    Enable = 1'b1;
    tick();
    exp_seg[0] = 8'h99;
    run_frame(4'd15, -1, -1, 144);

    // Reset during SHOW of digit 2 with a request pending.
    run_frame(4'd15, -1, -1, 55);
    Upd_Req = 1'b1;
    din[2]  = 8'h00;
    RST     = 1'b1;
    tick();
    check_dark("rst_mid_show", 1'b0);
    Upd_Req = 1'b0;
    tick();
    check_dark("rst_hold", 1'b0);
    RST = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) exp_seg[i] = 8'hFF;
    run_frame(4'd15, -1, -1, 144);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
